// File: rtl/ram_sp.sv
// ram_sp: single-port, flop-based synchronous RAM with registered,
// write-first read data. Async reset clears every word and the output.
module ram_sp #(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_BITS-1:0]    data_in,
  output logic [DATA_BITS-1:0]    data_out
);

  localparam int DEPTH = 2 ** ADDRESS_BITS;

  // Reject parameter values outside the supported range at elaboration.
  if (ADDRESS_BITS < 1 || ADDRESS_BITS > 12) begin : g_bad_address_bits
    $error("ram_sp: ADDRESS_BITS=%0d outside 1..12", ADDRESS_BITS);
  end
  if (DATA_BITS < 1 || DATA_BITS > 64) begin : g_bad_data_bits
    $error("ram_sp: DATA_BITS=%0d outside 1..64", DATA_BITS);
  end

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [DATA_BITS-1:0] data_out_q;
  logic [DATA_BITS-1:0] data_out_d;

  // Next-state: update the addressed word on write; read returns the new data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    mem_d      = mem_q;
    data_out_d = mem_q[address];
    if (write) begin
      mem_d[address] = data_in;
      data_out_d     = data_in;
    end
  end

  // State registers: array and output register, cleared by async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the array is built from flops precisely so that reset can clear every word.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_sp.sv
// tb_ram_sp: directed checks of ram_sp at the default 1/1 size and at 4/8.
`timescale 1ns/1ps
module tb_ram_sp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default-size instance (ADDRESS_BITS=1, DATA_BITS=1).
  logic       rst_a, wr_a;
  logic [0:0] addr_a, din_a, dout_a;
  // 16 x 8 instance.
  logic       rst_b, wr_b;
  logic [3:0] addr_b;
  logic [7:0] din_b, dout_b;

  ram_sp dut_a (
    .clock(clock), .reset(rst_a), .write(wr_a),
    .address(addr_a), .data_in(din_a), .data_out(dout_a)
  );

  ram_sp #(.ADDRESS_BITS(4), .DATA_BITS(8)) dut_b (
    .clock(clock), .reset(rst_b), .write(wr_b),
    .address(addr_b), .data_in(din_b), .data_out(dout_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge; return 1ns after the rising edge.
  task automatic step_a(input logic w, input logic a, input logic d);
    @(negedge clock);
    wr_a = w; addr_a = a; din_a = d;
    @(posedge clock);
    #1;
  endtask

  task automatic step_b(input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    wr_b = w; addr_b = a; din_b = d;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] pat;

  initial begin
    rst_a = 1'b1; wr_a = 1'b0; addr_a = '0; din_a = '0;
    rst_b = 1'b1; wr_b = 1'b0; addr_b = '0; din_b = '0;
    #1;
    check("a_reset_async", {63'd0, dout_a}, 64'd0);
    check("b_reset_async", {56'd0, dout_b}, 64'd0);
    @(posedge clock); @(posedge clock); #1;
    check("b_reset_held", {56'd0, dout_b}, 64'd0);
    @(negedge clock);
    rst_a = 1'b0; rst_b = 1'b0;

    // ---- default 1/1 instance ----
    step_a(1'b0, 1'b0, 1'b0); check("a_rd0_after_reset", {63'd0, dout_a}, 64'd0);
    step_a(1'b0, 1'b1, 1'b1); check("a_rd1_after_reset", {63'd0, dout_a}, 64'd0);
    step_a(1'b1, 1'b0, 1'b1); check("a_wr0_write_first", {63'd0, dout_a}, 64'd1);
    step_a(1'b0, 1'b0, 1'b0); check("a_rd0_after_wr",    {63'd0, dout_a}, 64'd1);
    step_a(1'b0, 1'b1, 1'b1); check("a_rd1_untouched",   {63'd0, dout_a}, 64'd0);
    step_a(1'b0, 1'b0, 1'b0); check("a_rd0_again",       {63'd0, dout_a}, 64'd1);

    // ---- 4/8 instance: write-first ----
    step_b(1'b1, 4'd5, 8'h11); check("b_wr5_11",         {56'd0, dout_b}, 64'h11);
    step_b(1'b0, 4'd5, 8'h00); check("b_rd5_11",         {56'd0, dout_b}, 64'h11);
    step_b(1'b1, 4'd5, 8'h5A); check("b_wr5_write_first",{56'd0, dout_b}, 64'h5A);
    step_b(1'b0, 4'd5, 8'h00); check("b_rd5_5a",         {56'd0, dout_b}, 64'h5A);

    // ---- async reset during a write cycle ----
    @(negedge clock);
    wr_b = 1'b1; addr_b = 4'd3; din_b = 8'hFF;
    #2 rst_b = 1'b1;
    #1 check("b_reset_mid_cycle", {56'd0, dout_b}, 64'd0);
    @(posedge clock); #1;
    check("b_reset_over_edge", {56'd0, dout_b}, 64'd0);
    @(negedge clock);
    rst_b = 1'b0; wr_b = 1'b0; addr_b = 4'd3; din_b = 8'h00;
    @(posedge clock); #1;
    check("b_rd3_write_cancelled", {56'd0, dout_b}, 64'd0);
    step_b(1'b0, 4'd5, 8'h00); check("b_rd5_cleared", {56'd0, dout_b}, 64'd0);

    // ---- full sweep ----
    for (int i = 0; i < 16; i++) begin
      pat = 8'(i) ^ 8'hA5;
      step_b(1'b1, 4'(i), pat);
    end
    for (int i = 0; i < 16; i++) begin
      pat = 8'(i) ^ 8'hA5;
      step_b(1'b0, 4'(i), 8'h00);
      check($sformatf("b_sweep_rd%0d", i), {56'd0, dout_b}, {56'd0, pat});
    end

    // ---- write disabled: data_in ignored ----
    for (int i = 0; i < 3; i++) begin
      step_b(1'b0, 4'd2, 8'h77);
      check($sformatf("b_wr_disabled_%0d", i), {56'd0, dout_b}, 64'hA7);
    end
    step_b(1'b0, 4'd7, 8'h77); check("b_rd7_neighbour", {56'd0, dout_b}, 64'hA2);
    step_b(1'b0, 4'd2, 8'h00); check("b_rd2_kept",      {56'd0, dout_b}, 64'hA7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
